// File: rtl/ipsxe_floating_point_fx2fl_pkg.sv
// rtl/ipsxe_floating_point_fx2fl_pkg.sv - shared constants and helpers for the fx2fl converter path
package ipsxe_floating_point_fx2fl_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int IN_W     = 32;

  // Bit index of the highest set bit in a byte; 0 when the byte is empty.
  function automatic logic [2:0] clog2_lead(input logic [7:0] b);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) pos = 3'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_lead_one_byte_v1_0.sv
// rtl/ipsxe_floating_point_lead_one_byte_v1_0.sv - per-byte leading-one flag and position
module ipsxe_floating_point_lead_one_byte_v1_0
  import ipsxe_floating_point_fx2fl_pkg::*;
(
  input  logic [7:0] lead_byte_i,
  output logic       nz_o,
  output logic [2:0] pos_o
);

  assign nz_o  = |lead_byte_i;
  assign pos_o = clog2_lead(lead_byte_i);

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_norm_v1_0.sv
// rtl/ipsxe_floating_point_fx2fl_norm_v1_0.sv - 3-stage fixed-point to IEEE-754 single converter
module ipsxe_floating_point_fx2fl_norm_v1_0
  import ipsxe_floating_point_fx2fl_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic              i_aclk,
  input  logic              i_areset_n,
  input  logic              i_aclken,
  input  logic              i_valid,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_valid,
  output logic [IN_W-1:0]   o_result,
  output logic              o_inexact
);

  logic              s1_valid_q, s1_sign_q, s1_zero_q;
  logic [IN_W-1:0]   s1_mag_q, s1_mag_d;

  logic              s2_valid_q, s2_sign_q, s2_zero_q;
  logic [IN_W-1:0]   s2_mag_q;
  logic [4:0]        s2_pos_q, s2_pos_d;

  logic              o_valid_q, o_inexact_q, o_inexact_d;
  logic [IN_W-1:0]   o_result_q, o_result_d;

  // Two's-complement negate; -2^31 maps onto 0x8000_0000 as an unsigned magnitude.
  assign s1_mag_d = i_data[IN_W-1] ? (~i_data + 32'd1) : i_data;

  logic [3:0] grp_nz;
  logic [2:0] grp_pos [4];

  for (genvar k = 0; k < 4; k++) begin : g_lead
    ipsxe_floating_point_lead_one_byte_v1_0 u_lead (
      .lead_byte_i (s1_mag_q[8*k +: 8]),
      .nz_o        (grp_nz[k]),
      .pos_o       (grp_pos[k])
    );
  end

  always_comb begin
    s2_pos_d = 5'd0;
    if (grp_nz[3])      s2_pos_d = {2'd3, grp_pos[3]};
    else if (grp_nz[2]) s2_pos_d = {2'd2, grp_pos[2]};
    else if (grp_nz[1]) s2_pos_d = {2'd1, grp_pos[1]};
    else                s2_pos_d = {2'd0, grp_pos[0]};
  end

  logic              right_shift;
  logic [4:0]        lshift, rshift, gidx;
  logic [IN_W-1:0]   guard_mask, sticky_mask;
  logic [MANT_W-1:0] frac, frac_rnd;
  logic              guard, sticky, inc, carry;
  logic [8:0]        exp_sum;

  always_comb begin
    right_shift = (s2_pos_q > 5'(MANT_W));
    lshift      = 5'(MANT_W) - s2_pos_q;
    rshift      = s2_pos_q - 5'(MANT_W);
    gidx        = s2_pos_q - 5'(MANT_W + 1);
    guard_mask  = 32'd1 << gidx;
    sticky_mask = guard_mask - 32'd1;
    // The hidden bit is implicit, so only the 23 fraction bits are kept.
    frac        = right_shift ? MANT_W'(s2_mag_q >> rshift) : MANT_W'(s2_mag_q << lshift);
    guard       = right_shift & (|(s2_mag_q & guard_mask));
    sticky      = right_shift & (|(s2_mag_q & sticky_mask));
    inc         = guard & (sticky | frac[0]);
    carry       = inc & (&frac);
    frac_rnd    = frac + MANT_W'(inc);
    exp_sum     = 9'(EXP_BIAS) + {4'd0, s2_pos_q} - 9'(FRAC_BITS) + {8'd0, carry};
    o_result_d  = {s2_sign_q, exp_sum[EXP_W-1:0], frac_rnd};
    o_inexact_d = guard | sticky;
    if (s2_zero_q) begin
      o_result_d  = '0;
      o_inexact_d = 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_mag_q    <= '0;
      s2_pos_q    <= '0;
      o_valid_q   <= 1'b0;
      o_result_q  <= '0;
      o_inexact_q <= 1'b0;
    end else if (i_aclken) begin
      s1_valid_q  <= i_valid;
      s1_sign_q   <= i_data[IN_W-1];
      s1_zero_q   <= (i_data == '0);
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= s1_zero_q;
      s2_mag_q    <= s1_mag_q;
      s2_pos_q    <= s2_pos_d;
      o_valid_q   <= s2_valid_q;
      o_result_q  <= o_result_d;
      o_inexact_q <= o_inexact_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_result  = o_result_q;
  assign o_inexact = o_inexact_q;

endmodule

// File: tb/tb_ipsxe_floating_point_fx2fl_norm_v1_0.sv
// tb/tb_ipsxe_floating_point_fx2fl_norm_v1_0.sv - directed bench for the fx2fl converter core
module tb_ipsxe_floating_point_fx2fl_norm_v1_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] data = 32'd0;

  logic        o_valid0, o_inexact0, o_valid1, o_inexact1;
  logic [31:0] o_result0, o_result1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_fx2fl_norm_v1_0 #(.FRAC_BITS(0)) dut0 (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_valid(valid), .i_data(data),
    .o_valid(o_valid0), .o_result(o_result0), .o_inexact(o_inexact0)
  );

  ipsxe_floating_point_fx2fl_norm_v1_0 #(.FRAC_BITS(16)) dut1 (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_valid(valid), .i_data(data),
    .o_valid(o_valid1), .o_result(o_result1), .o_inexact(o_inexact1)
  );

  // Drive one word for one enabled cycle, then wait until it reaches the output.
  task automatic send_one(input logic [31:0] w);
    @(negedge clk);
    en = 1'b1; valid = 1'b1; data = w;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; data = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid0 !== 1'b0 || o_result0 !== 32'h0 || o_inexact0 !== 1'b0) begin
      errors++;
      $display("FAIL reset0: got v=%b r=%h x=%b want v=0 r=00000000 x=0", o_valid0, o_result0, o_inexact0);
    end
    checks++;
    if (o_valid1 !== 1'b0 || o_result1 !== 32'h0 || o_inexact1 !== 1'b0) begin
      errors++;
      $display("FAIL reset1: got v=%b r=%h x=%b want v=0 r=00000000 x=0", o_valid1, o_result1, o_inexact1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] din [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] dexp[4] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      send_one(din[i]);
      checks++;
      if (o_valid0 !== 1'b1 || o_result0 !== dexp[i] || o_inexact0 !== 1'b0) begin
        errors++;
        $display("FAIL basic[%0d] in=%h: got v=%b r=%h x=%b want v=1 r=%h x=0",
                 i, din[i], o_valid0, o_result0, o_inexact0, dexp[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] din [3] = '{32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003};
    logic [31:0] dexp[3] = '{32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002};
    for (int i = 0; i < 3; i++) begin
      send_one(din[i]);
      checks++;
      if (o_valid0 !== 1'b1 || o_result0 !== dexp[i] || o_inexact0 !== 1'b1) begin
        errors++;
        $display("FAIL round[%0d] in=%h: got v=%b r=%h x=%b want v=1 r=%h x=1",
                 i, din[i], o_valid0, o_result0, o_inexact0, dexp[i]);
      end
    end
  endtask

  task automatic test_frac16();
    logic [31:0] din [2] = '{32'h0001_8000, 32'hFFFF_0000};
    logic [31:0] dexp[2] = '{32'h3FC0_0000, 32'hBF80_0000};
    for (int i = 0; i < 2; i++) begin
      send_one(din[i]);
      checks++;
      if (o_valid1 !== 1'b1 || o_result1 !== dexp[i] || o_inexact1 !== 1'b0) begin
        errors++;
        $display("FAIL frac16[%0d] in=%h: got v=%b r=%h x=%b want v=1 r=%h x=0",
                 i, din[i], o_valid1, o_result1, o_inexact1, dexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat = 8'b1011_0110;
    logic       obs [12];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      en = 1'b1;
      valid = (c < 8) ? pat[c] : 1'b0;
      data = 32'(c + 1);
      @(posedge clk);
      #1;
      obs[c] = o_valid0;
    end
    @(negedge clk);
    valid = 1'b0; data = 32'd0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs[c+2] !== pat[c]) begin
        errors++;
        $display("FAIL gap[%0d]: got o_valid=%b want %b", c, obs[c+2], pat[c]);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] vin [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h0000_0003};
    logic [31:0] vexp[8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000, 32'h0000_0000,
                             32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4040_0000};
    logic        vx  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  pv;
    int          pidx [3];
    int          sent, got, cyc;
    logic        prev_v, prev_x;
    logic [31:0] prev_r;
    sent = 0; got = 0; pv = 3'b000;
    pidx = '{0, 0, 0};
    for (cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) >= 3);
      valid = (sent < 8);
      data = (sent < 8) ? vin[sent] : 32'd0;
      prev_v = o_valid0; prev_r = o_result0; prev_x = o_inexact0;
      @(posedge clk);
      #1;
      if (en) begin
        pv = {pv[1:0], valid};
        pidx[2] = pidx[1]; pidx[1] = pidx[0]; pidx[0] = sent;
        if (valid) sent++;
        checks++;
        if (o_valid0 !== pv[2]) begin
          errors++;
          $display("FAIL stream_valid cyc=%0d: got %b want %b", cyc, o_valid0, pv[2]);
        end
        if (pv[2]) begin
          checks++;
          if (pidx[2] !== got || o_result0 !== vexp[got] || o_inexact0 !== vx[got]) begin
            errors++;
            $display("FAIL stream_word[%0d]: got r=%h x=%b want r=%h x=%b",
                     got, o_result0, o_inexact0, vexp[got], vx[got]);
          end
          got++;
        end
      end else begin
        checks++;
        if (o_valid0 !== prev_v || o_result0 !== prev_r || o_inexact0 !== prev_x) begin
          errors++;
          $display("FAIL stream_hold cyc=%0d: got v=%b r=%h x=%b want v=%b r=%h x=%b",
                   cyc, o_valid0, o_result0, o_inexact0, prev_v, prev_r, prev_x);
        end
      end
    end
    @(negedge clk);
    en = 1'b1; valid = 1'b0; data = 32'd0;
    checks++;
    if (got !== 8) begin
      errors++;
      $display("FAIL stream_count: got %0d words want 8", got);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; valid = 1'b1; data = 32'(i + 1);
      @(posedge clk);
    end
    #1;
    checks++;
    if (o_valid0 !== 1'b1 || o_result0 !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL pre_reset: got v=%b r=%h want v=1 r=3f800000", o_valid0, o_result0);
    end
    @(negedge clk);
    valid = 1'b0; data = 32'd0; rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid0 !== 1'b0 || o_result0 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%h want v=0 r=00000000", o_valid0, o_result0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_valid0 !== 1'b0) begin
        errors++;
        $display("FAIL flushed[%0d]: got o_valid=%b want 0", c, o_valid0);
      end
    end
    send_one(32'h0000_0002);
    checks++;
    if (o_valid0 !== 1'b1 || o_result0 !== 32'h4000_0000 || o_inexact0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got v=%b r=%h x=%b want v=1 r=40000000 x=0",
               o_valid0, o_result0, o_inexact0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_frac16();
    test_back_to_back();
    test_stream();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
